bnn_uart_rx: RTL and testbench

BNN_UART_RX -- requirements
Module: bnn_uart_rx

---
 rtl/bnn_pkg.sv | 28 ++
 rtl/bnn_sync_fifo.sv | 67 ++++++
 rtl/bnn_uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_bnn_uart_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and constants for the BNN UART receive path
//
// Contents:
//   OVERSAMPLE   samples per serial bit
//   rx_state_t   receive FSM state encoding
//   byte_t       one received byte
//   calc_div     clock divider for the oversample tick, rounded to nearest, at least 1
package bnn_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  typedef logic [7:0] byte_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/bnn_sync_fifo.sv
// rtl/bnn_sync_fifo.sv - single-clock FIFO buffering received bytes
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_data      push request and data
//   rd_en               pop request (ignored while empty)
//   rd_data             head entry, zero while empty
//   full, empty, count  occupancy status
module bnn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_fire;
  logic             wr_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_fire = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bnn_uart_rx.sv
// rtl/bnn_uart_rx.sv - 16x oversampled UART receiver with byte FIFO and CTS flow control
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   UART_Rx       serial line from host, idle high
//   UART_CTS      high = host may send, low = host must pause
//   rx_data       byte at FIFO head
//   rx_valid      FIFO non-empty
//   rx_ready      consumer accepts head byte when rx_valid is also high
//   frame_err     one-cycle pulse on a bad stop bit
//   overrun       one-cycle pulse when a good byte is dropped on a full FIFO
module bnn_uart_rx
  import bnn_pkg::*;
#(
  parameter int CLK_HZ     = 16_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_Rx,
  output logic       UART_CTS,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]    CTS_OFF   = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0]    CTS_ON    = CW'(FIFO_DEPTH - 4);

  logic             rx_s1, rx_s2, rx_prev;
  logic             line_fall;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             div_restart;

  rx_state_t        state, state_n;
  logic [3:0]       tick_cnt, tick_n;
  logic [2:0]       bit_idx, bit_n;
  byte_t            shift_q, shift_n;
  logic             fifo_wr;
  logic             ferr_n, ovr_n;

  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             rd_fire;

  // Synchronizer and edge-detect history reset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_Rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign line_fall = rx_prev && !rx_s2;

  // Oversample divider; restarting on the start edge aligns sample points to the frame.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_restart || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign rx_valid = !fifo_empty;
  assign rd_fire  = rx_ready && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_idx   <= bit_n;
      shift_q   <= shift_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_idx;
    shift_n     = shift_q;
    fifo_wr     = 1'b0;
    ferr_n      = 1'b0;
    ovr_n       = 1'b0;
    div_restart = 1'b0;

    case (state)
      ST_IDLE: begin
        if (line_fall) begin
          state_n     = ST_START;
          tick_n      = '0;
          div_restart = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_n = '0;
            if (!rx_s2) begin
              state_n = ST_DATA;
              bit_n   = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end

      // From here the 4-bit tick counter wraps every 16 ticks, landing on each bit mid-point.
      ST_DATA: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == TICK_LAST) begin
            shift_n = {rx_s2, shift_q[7:1]};
            if (bit_idx == 3'd7) begin
              state_n = ST_STOP;
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == TICK_LAST) begin
            if (rx_s2) begin
              state_n = ST_IDLE;
              if (!fifo_full || rd_fire) begin
                fifo_wr = 1'b1;
              end else begin
                ovr_n = 1'b1;
              end
            end else begin
              state_n = ST_WAIT_IDLE;
              ferr_n  = 1'b1;
            end
          end
        end
      end

      // Hold here through a break so a long low line yields a single frame error.
      ST_WAIT_IDLE: begin
        if (rx_s2) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  bnn_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (shift_q),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // CTS hysteresis: drop near full, re-raise only once well drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UART_CTS <= 1'b1;
    end else if (fifo_count >= CTS_OFF) begin
      UART_CTS <= 1'b0;
    end else if (fifo_count <= CTS_ON) begin
      UART_CTS <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bnn_uart_rx.sv
// tb/tb_bnn_uart_rx.sv - scoreboard testbench for bnn_uart_rx at 250 kbaud, 16 MHz
module tb_bnn_uart_rx;

  logic       clk;
  logic       rst;
  logic       UART_Rx;
  logic       UART_CTS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  bnn_uart_rx #(
    .CLK_HZ     (16_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .UART_Rx   (UART_Rx),
    .UART_CTS  (UART_CTS),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            failures++;
            $display("FAIL rx_data: got 0x%0h expected 0x%0h", rx_data, e);
          end
        end
      end
    end
    prev_valid = rst ? 1'b0 : rx_valid;
  end

  // One frame, 64 cycles per bit; optional one-cycle rx_ready pulse at ready_at and early abort.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                            input int ready_at, input int abort_at);
    int total;
    total = 576 + stop_len;
    for (int i = 0; i < total; i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      @(posedge clk); #1;
      if (i == 0) start_cyc = cyc;
      if (i < 64)       UART_Rx = 1'b0;
      else if (i < 576) UART_Rx = b[(i - 64) / 64];
      else              UART_Rx = stop_val;
      if (i == ready_at) rx_ready = 1'b1;
      else if (ready_at >= 0 && i == ready_at + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit expect_it);
    if (expect_it) exp_q.push_back(b);
    send_frame(b, 1'b1, 64, -1, -1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_one();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(posedge clk); #1 rx_ready = 1'b1;
    while ((exp_q.size() != 0 || rx_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    chk({name, "_valid_low"}, int'(rx_valid), 0);
  endtask

  initial begin
    int f0, o0;
    rst      = 1'b1;
    UART_Rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_cts", int'(UART_CTS), 1);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(20);

    // Single byte with exact valid latency and one-cycle drop after accept.
    send(8'hA5, 1'b1);
    idle(4);
    chk("a5_latency", rise_cyc - start_cyc, 611);
    chk("a5_valid", int'(rx_valid), 1);
    chk("a5_data", int'(rx_data), 8'hA5);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("a5_valid_fall", int'(rx_valid), 0);
    chk("a5_queue", exp_q.size(), 0);

    // Break-style bad stop bit, then a clean byte.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 200, -1, -1);
    @(posedge clk); #1 UART_Rx = 1'b1;
    idle(100);
    chk("ferr_once", ferr_cnt - f0, 1);
    chk("ferr_no_write", int'(rx_valid), 0);
    send(8'h5A, 1'b1);
    idle(4);
    drain("after_ferr");

    // CTS hysteresis over six buffered bytes.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    idle(4);
    chk("cts_5_bytes", int'(UART_CTS), 1);
    send(8'h06, 1'b1);
    idle(4);
    chk("cts_6_bytes", int'(UART_CTS), 0);
    read_one();
    idle(2);
    chk("cts_5_hold", int'(UART_CTS), 0);
    read_one();
    idle(2);
    chk("cts_4_high", int'(UART_CTS), 1);
    drain("cts");

    // Overrun on ninth byte.
    o0 = ovr_cnt;
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i), i < 8);
    idle(4);
    chk("overrun_once", ovr_cnt - o0, 1);
    chk("full_cts", int'(UART_CTS), 0);
    drain("overrun");

    // Ninth stop sample coincides with a read: no overrun.
    o0 = ovr_cnt;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b1);
    exp_q.push_back(8'h18);
    send_frame(8'h18, 1'b1, 64, 610, -1);
    idle(4);
    chk("no_overrun", ovr_cnt - o0, 0);
    chk("full_again", exp_q.size(), 8);
    drain("read_write");

    // Short glitch is rejected and the receiver still works afterwards.
    f0 = ferr_cnt;
    @(posedge clk); #1 UART_Rx = 1'b0;
    idle(30);
    UART_Rx = 1'b1;
    idle(200);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_no_byte", int'(rx_valid), 0);
    send(8'hC3, 1'b1);
    idle(4);
    drain("after_glitch");

    // Reset mid-frame with buffered bytes.
    send(8'h21, 1'b1);
    send(8'h22, 1'b1);
    idle(4);
    chk("pre_rst_valid", int'(rx_valid), 1);
    send_frame(8'hFF, 1'b1, 64, -1, 350);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(rx_valid), 0);
    chk("mid_rst_cts", int'(UART_CTS), 1);
    exp_q.delete();
    UART_Rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);
    chk("post_rst_valid", int'(rx_valid), 0);
    send(8'h81, 1'b1);
    idle(4);
    chk("post_rst_data", int'(rx_data), 8'h81);
    drain("after_rst");

    chk("total_overruns", ovr_cnt, 1);
    chk("total_frame_errs", ferr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
